// File: rtl/tlb_translation.sv
// MIPS32 virtual-to-physical translation: fixed kseg0/kseg1 mapping plus an
// N-entry fully associative 4 KB-page TLB with a CP0-side write/read/probe port.
module tlb_translation #(
    parameter int TLB_ENTRIES = 16,
    parameter int ASID_WIDTH  = 8,
    parameter int IDX_W       = $clog2(TLB_ENTRIES),
    parameter int ENTRY_W     = 70 + ASID_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    input  logic [31:0]           req_vaddr,
    input  logic                  req_store,
    input  logic [ASID_WIDTH-1:0] cur_asid,
    input  logic                  flush,
    output logic                  resp_valid,
    output logic [31:0]           resp_paddr,
    output logic                  resp_uncached,
    output logic                  resp_refill,
    output logic                  resp_invalid,
    output logic                  resp_modified,
    input  logic                  tlb_we,
    input  logic [IDX_W-1:0]      tlb_windex,
    input  logic [ENTRY_W-1:0]    tlb_wentry,
    input  logic                  tlbr_en,
    input  logic [IDX_W-1:0]      tlbr_index,
    output logic [ENTRY_W-1:0]    tlbr_entry,
    input  logic                  tlbp_en,
    input  logic [18:0]           tlbp_vpn2,
    input  logic [ASID_WIDTH-1:0] tlbp_asid,
    output logic                  tlbp_done,
    output logic                  tlbp_hit,
    output logic [IDX_W-1:0]      tlbp_index
);

    localparam int V1_BIT   = 0;
    localparam int D1_BIT   = 1;
    localparam int C1_LSB   = 2;
    localparam int PFN1_LSB = 5;
    localparam int V0_BIT   = 25;
    localparam int D0_BIT   = 26;
    localparam int C0_LSB   = 27;
    localparam int PFN0_LSB = 30;
    localparam int G_BIT    = 50;
    localparam int ASID_LSB = 51;
    localparam int VPN_LSB  = 51 + ASID_WIDTH;

    logic [ENTRY_W-1:0] tlb [TLB_ENTRIES];

    function automatic logic entry_match(input logic [ENTRY_W-1:0] e,
                                         input logic [18:0] vpn2,
                                         input logic [ASID_WIDTH-1:0] asid);
        return (e[VPN_LSB +: 19] == vpn2) &&
               (e[G_BIT] || (e[ASID_LSB +: ASID_WIDTH] == asid));
    endfunction

    // Descending scan so the lowest matching index is the one left standing.
    logic             lk_hit;
    logic [IDX_W-1:0] lk_idx;
    logic             pr_hit;
    logic [IDX_W-1:0] pr_idx;

    always_comb begin
        lk_hit = 1'b0;
        lk_idx = '0;
        pr_hit = 1'b0;
        pr_idx = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (entry_match(tlb[i], req_vaddr[31:13], cur_asid)) begin
                lk_hit = 1'b1;
                lk_idx = IDX_W'(i);
            end
            if (entry_match(tlb[i], tlbp_vpn2, tlbp_asid)) begin
                pr_hit = 1'b1;
                pr_idx = IDX_W'(i);
            end
        end
    end

    logic [ENTRY_W-1:0] lk_entry;
    logic [19:0]        sel_pfn;
    logic [2:0]         sel_c;
    logic               sel_d;
    logic               sel_v;
    logic               unmapped;
    logic [31:0]        paddr_p0;
    logic               uncached_p0;
    logic               refill_p0;
    logic               invalid_p0;
    logic               modified_p0;

    always_comb begin
        lk_entry = tlb[lk_idx];
        sel_pfn  = req_vaddr[12] ? lk_entry[PFN1_LSB +: 20] : lk_entry[PFN0_LSB +: 20];
        sel_c    = req_vaddr[12] ? lk_entry[C1_LSB +: 3]    : lk_entry[C0_LSB +: 3];
        sel_d    = req_vaddr[12] ? lk_entry[D1_BIT]         : lk_entry[D0_BIT];
        sel_v    = req_vaddr[12] ? lk_entry[V1_BIT]         : lk_entry[V0_BIT];
        unmapped = (req_vaddr[31:30] == 2'b10);

        paddr_p0    = '0;
        uncached_p0 = 1'b0;
        refill_p0   = 1'b0;
        invalid_p0  = 1'b0;
        modified_p0 = 1'b0;
        if (unmapped) begin
            paddr_p0    = {3'b000, req_vaddr[28:0]};
            uncached_p0 = req_vaddr[29];
        end else if (!lk_hit) begin
            refill_p0 = 1'b1;
        end else begin
            paddr_p0    = {sel_pfn, req_vaddr[11:0]};
            uncached_p0 = (sel_c == 3'd2);
            invalid_p0  = !sel_v;
            modified_p0 = sel_v && req_store && !sel_d;
        end
    end

    // Stage p0 -> p1: registered lookup response, probe result and read data
    always_ff @(posedge clk) begin
        if (!resetn) begin
            resp_valid    <= 1'b0;
            resp_paddr    <= '0;
            resp_uncached <= 1'b0;
            resp_refill   <= 1'b0;
            resp_invalid  <= 1'b0;
            resp_modified <= 1'b0;
            tlbr_entry    <= '0;
            tlbp_done     <= 1'b0;
            tlbp_hit      <= 1'b0;
            tlbp_index    <= '0;
        end else begin
            resp_valid <= req_valid && !flush;
            if (req_valid && !flush) begin
                resp_paddr    <= paddr_p0;
                resp_uncached <= uncached_p0;
                resp_refill   <= refill_p0;
                resp_invalid  <= invalid_p0;
                resp_modified <= modified_p0;
            end
            tlbp_done <= tlbp_en;
            if (tlbp_en) begin
                tlbp_hit   <= pr_hit;
                tlbp_index <= pr_idx;
            end
            if (tlbr_en) begin
                tlbr_entry <= tlb[tlbr_index];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                tlb[i] <= '0;
            end
        end else if (tlb_we) begin
            tlb[tlb_windex] <= tlb_wentry;
        end
    end

endmodule

// File: tb/tb_tlb_translation.sv
// Directed bench for tlb_translation: unmapped segments, TLB hits and faults,
// write collision, probe/read, flush and reset.
module tb_tlb_translation;

    localparam int TLB_ENTRIES = 16;
    localparam int ASID_WIDTH  = 8;
    localparam int IDX_W       = 4;
    localparam int ENTRY_W     = 78;

    logic                  clk = 1'b0;
    logic                  resetn;
    logic                  req_valid;
    logic [31:0]           req_vaddr;
    logic                  req_store;
    logic [ASID_WIDTH-1:0] cur_asid;
    logic                  flush;
    logic                  resp_valid;
    logic [31:0]           resp_paddr;
    logic                  resp_uncached;
    logic                  resp_refill;
    logic                  resp_invalid;
    logic                  resp_modified;
    logic                  tlb_we;
    logic [IDX_W-1:0]      tlb_windex;
    logic [ENTRY_W-1:0]    tlb_wentry;
    logic                  tlbr_en;
    logic [IDX_W-1:0]      tlbr_index;
    logic [ENTRY_W-1:0]    tlbr_entry;
    logic                  tlbp_en;
    logic [18:0]           tlbp_vpn2;
    logic [ASID_WIDTH-1:0] tlbp_asid;
    logic                  tlbp_done;
    logic                  tlbp_hit;
    logic [IDX_W-1:0]      tlbp_index;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ENTRY_W-1:0] e3, e7, e2, e9;

    tlb_translation #(
        .TLB_ENTRIES(TLB_ENTRIES),
        .ASID_WIDTH (ASID_WIDTH)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_vaddr    (req_vaddr),
        .req_store    (req_store),
        .cur_asid     (cur_asid),
        .flush        (flush),
        .resp_valid   (resp_valid),
        .resp_paddr   (resp_paddr),
        .resp_uncached(resp_uncached),
        .resp_refill  (resp_refill),
        .resp_invalid (resp_invalid),
        .resp_modified(resp_modified),
        .tlb_we       (tlb_we),
        .tlb_windex   (tlb_windex),
        .tlb_wentry   (tlb_wentry),
        .tlbr_en      (tlbr_en),
        .tlbr_index   (tlbr_index),
        .tlbr_entry   (tlbr_entry),
        .tlbp_en      (tlbp_en),
        .tlbp_vpn2    (tlbp_vpn2),
        .tlbp_asid    (tlbp_asid),
        .tlbp_done    (tlbp_done),
        .tlbp_hit     (tlbp_hit),
        .tlbp_index   (tlbp_index)
    );

    always #5 clk = ~clk;

    function automatic logic [ENTRY_W-1:0] make_entry(
        input logic [18:0] vpn2, input logic [7:0] asid, input logic g,
        input logic [19:0] pfn0, input logic [2:0] c0, input logic d0, input logic v0,
        input logic [19:0] pfn1, input logic [2:0] c1, input logic d1, input logic v1);
        return {vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1};
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // flags packed as {valid, uncached, refill, invalid, modified}
    function automatic logic [4:0] flags();
        return {resp_valid, resp_uncached, resp_refill, resp_invalid, resp_modified};
    endfunction

    task automatic lookup(input logic [31:0] va, input logic [7:0] asid, input logic st);
        req_valid = 1'b1;
        req_vaddr = va;
        cur_asid  = asid;
        req_store = st;
        step();
        req_valid = 1'b0;
        req_store = 1'b0;
    endtask

    task automatic write_tlb(input logic [IDX_W-1:0] idx, input logic [ENTRY_W-1:0] e);
        tlb_we     = 1'b1;
        tlb_windex = idx;
        tlb_wentry = e;
        step();
        tlb_we = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; req_valid = 1'b0; req_vaddr = '0; req_store = 1'b0;
        cur_asid = '0; flush = 1'b0; tlb_we = 1'b0; tlb_windex = '0;
        tlb_wentry = '0; tlbr_en = 1'b0; tlbr_index = '0; tlbp_en = 1'b0;
        tlbp_vpn2 = '0; tlbp_asid = '0;

        e3 = make_entry(19'h00040, 8'd5, 1'b0, 20'h12345, 3'd3, 1'b1, 1'b1,
                        20'h0ABCD, 3'd2, 1'b0, 1'b0);
        e9 = make_entry(19'h00100, 8'd0, 1'b1, 20'h00777, 3'd2, 1'b1, 1'b1,
                        20'h0, 3'd0, 1'b0, 1'b0);
        e7 = make_entry(19'h00300, 8'd5, 1'b0, 20'h07777, 3'd3, 1'b1, 1'b1,
                        20'h07778, 3'd3, 1'b1, 1'b1);
        e2 = make_entry(19'h00300, 8'd5, 1'b0, 20'h02222, 3'd3, 1'b1, 1'b1,
                        20'h02223, 3'd3, 1'b1, 1'b1);

        step(); step();
        check_eq("reset_flags", 128'(flags()), 128'(5'b00000));
        check_eq("reset_paddr", 128'(resp_paddr), 128'h0);
        check_eq("reset_tlbr", 128'(tlbr_entry), 128'h0);
        check_eq("reset_probe", 128'({tlbp_done, tlbp_hit, tlbp_index}), 128'h0);
        resetn = 1'b1;
        step();

        lookup(32'h8000_1234, 8'd0, 1'b0);
        check_eq("kseg0_paddr", 128'(resp_paddr), 128'h0000_1234);
        check_eq("kseg0_flags", 128'(flags()), 128'(5'b10000));
        step();
        check_eq("idle_valid", 128'(resp_valid), 128'h0);
        check_eq("idle_hold_paddr", 128'(resp_paddr), 128'h0000_1234);

        lookup(32'hBFC0_0000, 8'd0, 1'b0);
        check_eq("kseg1_paddr", 128'(resp_paddr), 128'h1FC0_0000);
        check_eq("kseg1_flags", 128'(flags()), 128'(5'b11000));

        // Write and lookup in the same cycle: lookup sees the empty slot.
        tlb_we = 1'b1; tlb_windex = 4'd3; tlb_wentry = e3;
        lookup(32'h0008_0ABC, 8'd5, 1'b0);
        tlb_we = 1'b0;
        check_eq("collide_flags", 128'(flags()), 128'(5'b10100));
        check_eq("collide_paddr", 128'(resp_paddr), 128'h0);

        lookup(32'h0008_0ABC, 8'd5, 1'b0);
        check_eq("hit_paddr", 128'(resp_paddr), 128'h1234_5ABC);
        check_eq("hit_flags", 128'(flags()), 128'(5'b10000));

        lookup(32'h0008_0ABC, 8'd6, 1'b0);
        check_eq("asid_miss_flags", 128'(flags()), 128'(5'b10100));

        lookup(32'h0008_1ABC, 8'd5, 1'b0);
        check_eq("invalid_flags", 128'(flags()), 128'(5'b11010));
        check_eq("invalid_paddr", 128'(resp_paddr), 128'h0ABC_DABC);

        lookup(32'h0008_0ABC, 8'd5, 1'b1);
        check_eq("store_dirty_flags", 128'(flags()), 128'(5'b10000));

        write_tlb(4'd3, make_entry(19'h00040, 8'd5, 1'b0, 20'h12345, 3'd3, 1'b0, 1'b1,
                                   20'h0ABCD, 3'd2, 1'b0, 1'b0));
        lookup(32'h0008_0ABC, 8'd5, 1'b1);
        check_eq("modified_flags", 128'(flags()), 128'(5'b10001));
        check_eq("modified_paddr", 128'(resp_paddr), 128'h1234_5ABC);
        lookup(32'h0008_0ABC, 8'd5, 1'b0);
        check_eq("load_clean_flags", 128'(flags()), 128'(5'b10000));

        write_tlb(4'd9, e9);
        lookup(32'h0020_0010, 8'h33, 1'b0);
        check_eq("global_paddr", 128'(resp_paddr), 128'h0077_7010);
        check_eq("global_flags", 128'(flags()), 128'(5'b11000));

        write_tlb(4'd7, e7);
        write_tlb(4'd2, e2);
        tlbp_en = 1'b1; tlbp_vpn2 = 19'h00300; tlbp_asid = 8'd5;
        step();
        tlbp_en = 1'b0;
        check_eq("probe_dup", 128'({tlbp_done, tlbp_hit, tlbp_index}), 128'({1'b1, 1'b1, 4'd2}));
        step();
        check_eq("probe_done_pulse", 128'(tlbp_done), 128'h0);
        tlbp_en = 1'b1; tlbp_vpn2 = 19'h00301;
        step();
        tlbp_en = 1'b0;
        check_eq("probe_miss", 128'({tlbp_done, tlbp_hit, tlbp_index}), 128'({1'b1, 1'b0, 4'd0}));

        tlbr_en = 1'b1; tlbr_index = 4'd7;
        step();
        tlbr_en = 1'b0; tlbr_index = 4'd2;
        check_eq("tlbr_idx7", 128'(tlbr_entry), 128'(e7));
        step();
        check_eq("tlbr_hold", 128'(tlbr_entry), 128'(e7));

        lookup(32'h0060_0004, 8'd5, 1'b0);
        check_eq("dup_lowest_paddr", 128'(resp_paddr), 128'h0222_2004);

        flush = 1'b1;
        lookup(32'h8000_0040, 8'd0, 1'b0);
        flush = 1'b0;
        check_eq("flush_valid", 128'(resp_valid), 128'h0);
        check_eq("flush_hold_paddr", 128'(resp_paddr), 128'h0222_2004);

        // Reset arrives with a request and a write in flight.
        resetn = 1'b0;
        tlb_we = 1'b1; tlb_windex = 4'd3; tlb_wentry = e3;
        lookup(32'h8000_0040, 8'd0, 1'b0);
        tlb_we = 1'b0;
        check_eq("rst_mid_flags", 128'(flags()), 128'(5'b00000));
        check_eq("rst_mid_paddr", 128'(resp_paddr), 128'h0);
        check_eq("rst_mid_tlbr", 128'(tlbr_entry), 128'h0);
        resetn = 1'b1;
        lookup(32'h0008_0ABC, 8'd5, 1'b0);
        check_eq("post_rst_refill", 128'(flags()), 128'(5'b10100));
        lookup(32'h0020_0010, 8'h33, 1'b0);
        check_eq("post_rst_global", 128'(flags()), 128'(5'b10100));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tlb_translation.md
# tlb_translation

Parametrised MIPS32 virtual-to-physical translation unit for the mycpu pipeline, replacing the fixed kseg0/kseg1-only mapper. Unmapped segments (kseg0, kseg1) are translated by fixed rule. Mapped segments (useg, kseg2, kseg3) are translated through an N-entry, fully associative, 4 KB-page TLB. The TLB is written, read and probed through a CP0-side port. Lookup responses are registered, with one-cycle latency and a flush cancel.

## Interface
- TLB_ENTRIES, 16: number of TLB entries; power of two, 2..64.
- ASID_WIDTH, 8: ASID width.
- IDX_W, $clog2(TLB_ENTRIES): index width (derived).
- ENTRY_W, 70+ASID_WIDTH: packed entry width (derived).
- Entry layout, MSB to LSB: vpn2[18:0], asid, g, pfn0[19:0], c0[2:0], d0, v0, pfn1[19:0], c1[2:0], d1, v1.
- clk  in  1  sole clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- req_valid  in  1  lookup request this cycle.
- req_vaddr  in  32  virtual address.
- req_store  in  1  request is a store (dirty check).
- cur_asid  in  ASID_WIDTH  current ASID from CP0 EntryHi.
- flush  in  1  cancel the response due next cycle.
- resp_valid  out  1  registered response valid.
- resp_paddr  out  32  physical address.
- resp_uncached  out  1  access is uncached.
- resp_refill  out  1  TLB miss on a mapped address.
- resp_invalid  out  1  hit, but V=0.
- resp_modified  out  1  store hit, V=1, D=0.
- tlb_we  in  1  write tlb_wentry into tlb_windex (TLBWI/TLBWR).
- tlb_windex  in  IDX_W  write index.
- tlb_wentry  in  ENTRY_W  entry to write.
- tlbr_en  in  1  read request.
- tlbr_index  in  IDX_W  read index.
- tlbr_entry  out  ENTRY_W  registered read data.
- tlbp_en  in  1  probe request.
- tlbp_vpn2  in  19  probe VPN2.
- tlbp_asid  in  ASID_WIDTH  probe ASID.
- tlbp_done  out  1  probe result valid.
- tlbp_hit  out  1  probe matched.
- tlbp_index  out  IDX_W  matched index.

## Operation
- Segment decode on vaddr[31:29]:
  - 100 (kseg0): paddr = {3'b0, vaddr[28:0]}, uncached=0.
  - 101 (kseg1): paddr = {3'b0, vaddr[28:0]}, uncached=1.
  - Any other value: mapped. No fault flags are raised for unmapped addresses.
- Match rule: entry i matches when vpn2==vaddr[31:13] and (g || asid==cur_asid). If several entries match, the lowest index wins; this is defined behaviour, not an error.
- Page select: vaddr[12]=0 selects the even page (pfn0/c0/d0/v0); vaddr[12]=1 selects the odd page (pfn1/c1/d1/v1).
- Mapped paddr = {pfn, vaddr[11:0]}. uncached = (c==3'd2).
- Fault priority, exactly one flag or none: refill (no match), then invalid (V=0), then modified (req_store && D=0).
  - On any fault, paddr and uncached still carry the selected entry's values (0 on refill).
- Write: the entry updates at the clock edge where tlb_we=1. A lookup, probe or read in the same cycle sees the old contents.
- Probe: matches on tlbp_vpn2/tlbp_asid with the same rule and priority. On a miss, tlbp_index=0.
- Read: tlbr_entry holds the last read result until the next tlbr_en.
- Lookup, probe, read and write may all be asserted in the same cycle and are independent.

## Timing
- Lookup: req_valid at edge t gives resp_valid=1 with results for cycle t+1.
- resp_valid is 0 when req_valid was 0.
- flush at t suppresses the response due at t+1 (resp_valid=0). A request at t is then dropped, not replayed.
- Response payload holds its value while resp_valid=0. Consumers must gate on resp_valid.
- Probe: tlbp_en at t gives a tlbp_done pulse at t+1.
- Read: tlbr_en at t gives updated tlbr_entry at t+1.
- Reset (resetn=0 at an edge):
  - All entries are cleared to 0, so V=0 and G=0 everywhere.
  - resp_valid, resp_paddr, resp_uncached, resp_refill, resp_invalid, resp_modified, tlbr_entry, tlbp_done, tlbp_hit and tlbp_index all go to 0.
  - Any in-flight response is discarded. Reset takes priority over tlb_we.
- No stalls: one request per cycle, sustained.

## Test plan
- Unmapped: 0x8000_1234 gives paddr 0x0000_1234, uncached=0. 0xBFC0_0000 gives 0x1FC0_0000, uncached=1. Both have no fault flags and latency 1.
- Mapped hit: write idx 3 with vpn2=0x00040, asid=5, g=0, pfn0=0x12345, c0=3, v0=1, d0=1. Then load 0x0008_0ABC with cur_asid=5 gives paddr 0x1234_5ABC, uncached=0.
- Faults:
  - Same entry with cur_asid=6 gives refill.
  - 0x0008_1ABC with v1=0 gives invalid.
  - Store to the even page with d0=0 gives modified only.
- Write/lookup collision: tlb_we and a lookup of the same VPN in one cycle give refill; the same lookup one cycle later hits. Global entry (g=1) hits for any ASID.
- Probe/read: duplicate matches at idx 2 and 7 give tlbp_hit=1, tlbp_index=2. tlbr_index=7 returns the written entry one cycle later.
- Flush/reset: flush with a pending request gives resp_valid=0. resetn low mid-stream clears outputs. A subsequent mapped lookup gives refill.
